// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and constants for the reservation-station issue scheduler and dispatch.
package rs_issue_scheduler_pkg;

    localparam int unsigned RS_DEPTH_C = 16;
    localparam int unsigned NUM_FU_C   = 3;
    localparam int unsigned IDX_W_C    = $clog2(RS_DEPTH_C);

    localparam logic [1:0] FU_ALU0    = 2'd0;
    localparam logic [1:0] FU_ALU1    = 2'd1;
    localparam logic [1:0] FU_MEM     = 2'd2;
    localparam logic [1:0] FU_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        LN_IDLE,
        LN_WAIT,
        LN_SEL
    } ln_state_e;

endpackage

// File: rtl/rs_issue_scheduler_age_matrix.sv
// Relative-age matrix of RS lines: age[i][j]=1 means line i is older than line j.
// Provides one oldest-of query per issue port.
module rs_age_matrix
    import rs_issue_scheduler_pkg::*;
#(
    parameter int unsigned RS_DEPTH = RS_DEPTH_C,
    parameter int unsigned NUM_FU   = NUM_FU_C,
    parameter int unsigned IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               alloc_valid_1,
    input  logic [IDX_W-1:0]                   alloc_idx_1,
    input  logic                               alloc_valid_2,
    input  logic [IDX_W-1:0]                   alloc_idx_2,
    input  logic [RS_DEPTH-1:0]                occupied,
    input  logic [NUM_FU-1:0][RS_DEPTH-1:0]    query,
    output logic [NUM_FU-1:0]                  found,
    output logic [NUM_FU-1:0][IDX_W-1:0]       oldest
);

    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_nxt;

    // New lines become younger than every occupied line; slot 1 is older than slot 2.
    always_comb begin
        age_nxt = age;
        if (alloc_valid_1) age_nxt[alloc_idx_1] = '0;
        if (alloc_valid_2) age_nxt[alloc_idx_2] = '0;
        for (int unsigned j = 0; j < RS_DEPTH; j++) begin
            if (alloc_valid_1 && occupied[j] && (IDX_W'(j) != alloc_idx_1))
                age_nxt[j][alloc_idx_1] = 1'b1;
            if (alloc_valid_2 && (IDX_W'(j) != alloc_idx_2) &&
                (occupied[j] || (alloc_valid_1 && (IDX_W'(j) == alloc_idx_1))))
                age_nxt[j][alloc_idx_2] = 1'b1;
        end
    end

    // Matrix storage; clear has priority over allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        age <= '0;
        else if (clear) age <= '0;
        else            age <= age_nxt;
    end

    // Per query: the masked line with no older masked line wins.
    always_comb begin
        logic older;
        found  = '0;
        oldest = '0;
        older  = 1'b0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (query[f][i]) begin
                    older = 1'b0;
                    for (int unsigned j = 0; j < RS_DEPTH; j++)
                        if ((j != i) && query[f][j] && age[j][i]) older = 1'b1;
                    if (!older) begin
                        found[f]  = 1'b1;
                        oldest[f] = IDX_W'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Age-ordered issue scheduler: per-line WAIT/SEL tracking, oldest-ready select per FU,
// registered valid/ready issue ports, free pulses and occupancy count.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int unsigned RS_DEPTH = RS_DEPTH_C,
    parameter int unsigned NUM_FU   = NUM_FU_C,
    parameter int unsigned IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_valid_1,
    input  logic [IDX_W-1:0]        alloc_idx_1,
    input  logic [1:0]              alloc_fu_1,
    input  logic                    alloc_valid_2,
    input  logic [IDX_W-1:0]        alloc_idx_2,
    input  logic [1:0]              alloc_fu_2,
    input  logic [RS_DEPTH-1:0]     src_ready,
    input  logic [NUM_FU-1:0]       fu_ready,
    output logic [NUM_FU-1:0]       issue_valid,
    output logic [NUM_FU*IDX_W-1:0] issue_idx,
    output logic [RS_DEPTH-1:0]     rs_free,
    output logic [IDX_W:0]          occupancy,
    output logic                    alloc_err
);

    ln_state_e                          state [RS_DEPTH];
    logic [1:0]                         fu_q  [RS_DEPTH];
    logic [NUM_FU-1:0][IDX_W-1:0]       ix;
    logic [NUM_FU-1:0][RS_DEPTH-1:0]    cand;
    logic [NUM_FU-1:0]                  found;
    logic [NUM_FU-1:0][IDX_W-1:0]       oldest;
    logic [NUM_FU-1:0]                  load;
    logic [RS_DEPTH-1:0]                xfer_line;
    logic [RS_DEPTH-1:0]                sel_line;
    logic [RS_DEPTH-1:0]                occupied;
    logic [IDX_W:0]                     n_xfer;
    logic                               acc1;
    logic                               acc2;
    logic                               err_now;

    assign issue_idx = ix;

    // Candidates, handshakes and alloc legality from registered state.
    always_comb begin
        cand      = '0;
        xfer_line = '0;
        occupied  = '0;
        n_xfer    = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            occupied[i] = (state[i] != LN_IDLE);
            for (int unsigned f = 0; f < NUM_FU; f++)
                cand[f][i] = (state[i] == LN_WAIT) && (fu_q[i] == 2'(f)) && src_ready[i];
        end
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            load[f] = !issue_valid[f] || fu_ready[f];
            if (issue_valid[f] && fu_ready[f]) begin
                xfer_line[ix[f]] = 1'b1;
                n_xfer           = n_xfer + (IDX_W+1)'(1);
            end
        end
        // A line handed off this cycle may be re-allocated in the same cycle.
        acc1 = alloc_valid_1 && (alloc_fu_1 != FU_ILLEGAL) &&
               ((state[alloc_idx_1] == LN_IDLE) || xfer_line[alloc_idx_1]);
        acc2 = alloc_valid_2 && (alloc_fu_2 != FU_ILLEGAL) &&
               !(alloc_valid_1 && (alloc_idx_1 == alloc_idx_2)) &&
               ((state[alloc_idx_2] == LN_IDLE) || xfer_line[alloc_idx_2]);
        err_now = (alloc_valid_1 && !acc1) || (alloc_valid_2 && !acc2);
    end

    // Lines moved to SEL by the issue registers that load this cycle.
    always_comb begin
        sel_line = '0;
        for (int unsigned f = 0; f < NUM_FU; f++)
            if (load[f] && found[f]) sel_line[oldest[f]] = 1'b1;
    end

    rs_age_matrix #(
        .RS_DEPTH (RS_DEPTH),
        .NUM_FU   (NUM_FU),
        .IDX_W    (IDX_W)
    ) u_age (
        .clk           (clk),
        .rst           (rst),
        .clear         (flush),
        .alloc_valid_1 (acc1),
        .alloc_idx_1   (alloc_idx_1),
        .alloc_valid_2 (acc2),
        .alloc_idx_2   (alloc_idx_2),
        .occupied      (occupied),
        .query         (cand),
        .found         (found),
        .oldest        (oldest)
    );

    // Per-line state: alloc beats hand-off on the same line, flush beats everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                state[i] <= LN_IDLE;
                fu_q[i]  <= FU_ALU0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) state[i] <= LN_IDLE;
        end else begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (acc1 && (alloc_idx_1 == IDX_W'(i))) begin
                    state[i] <= LN_WAIT;
                    fu_q[i]  <= alloc_fu_1;
                end else if (acc2 && (alloc_idx_2 == IDX_W'(i))) begin
                    state[i] <= LN_WAIT;
                    fu_q[i]  <= alloc_fu_2;
                end else if (xfer_line[i]) begin
                    state[i] <= LN_IDLE;
                end else if (sel_line[i]) begin
                    state[i] <= LN_SEL;
                end
            end
        end
    end

    // Issue registers: reload when empty or draining, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= '0;
            ix          <= '0;
        end else if (flush) begin
            issue_valid <= '0;
        end else begin
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                if (load[f]) begin
                    issue_valid[f] <= found[f];
                    if (found[f]) ix[f] <= oldest[f];
                end
            end
        end
    end

    // Free pulses, occupancy counter and sticky alloc error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_free   <= '0;
            occupancy <= '0;
            alloc_err <= 1'b0;
        end else begin
            alloc_err <= alloc_err | err_now;
            if (flush) begin
                rs_free   <= '0;
                occupancy <= '0;
            end else begin
                rs_free   <= xfer_line;
                occupancy <= occupancy + (IDX_W+1)'(acc1) + (IDX_W+1)'(acc2) - n_xfer;
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: queue-based age model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rs_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid_1 = 1'b0;
    logic [3:0]  alloc_idx_1 = '0;
    logic [1:0]  alloc_fu_1 = '0;
    logic        alloc_valid_2 = 1'b0;
    logic [3:0]  alloc_idx_2 = '0;
    logic [1:0]  alloc_fu_2 = '0;
    logic [15:0] src_ready = '0;
    logic [2:0]  fu_ready = '0;
    logic [2:0]  issue_valid;
    logic [11:0] issue_idx;
    logic [15:0] rs_free;
    logic [4:0]  occupancy;
    logic        alloc_err;

    int errors = 0;
    int checks = 0;
    bit tb_done = 1'b0;

    always #5 clk = ~clk;

    rs_issue_scheduler #(
        .RS_DEPTH (16),
        .NUM_FU   (3),
        .IDX_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_valid_1 (alloc_valid_1),
        .alloc_idx_1   (alloc_idx_1),
        .alloc_fu_1    (alloc_fu_1),
        .alloc_valid_2 (alloc_valid_2),
        .alloc_idx_2   (alloc_idx_2),
        .alloc_fu_2    (alloc_fu_2),
        .src_ready     (src_ready),
        .fu_ready      (fu_ready),
        .issue_valid   (issue_valid),
        .issue_idx     (issue_idx),
        .rs_free       (rs_free),
        .occupancy     (occupancy),
        .alloc_err     (alloc_err)
    );

    task automatic cmp(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: per-line status (0 empty, 1 waiting, 2 issued) and an alloc-ordered queue.
    int       m_st [16];
    int       m_fu [16];
    int       m_ord [$];
    bit [2:0] m_iv;
    int       m_ix [3];
    bit [15:0] m_free;
    int       m_occ;
    bit       m_err;

    always @(posedge clk or posedge rst) begin
        bit [15:0] gone;
        int        win [3];
        bit        ok1, ok2;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin m_st[i] = 0; m_fu[i] = 0; end
            m_ord.delete();
            m_iv = '0; m_free = '0; m_occ = 0; m_err = 1'b0;
            for (int f = 0; f < 3; f++) m_ix[f] = 0;
        end else begin
            gone = '0;
            for (int f = 0; f < 3; f++) if (m_iv[f] && fu_ready[f]) gone[m_ix[f]] = 1'b1;
            ok1 = alloc_valid_1 && alloc_fu_1 != 2'd3 && (m_st[alloc_idx_1] == 0 || gone[alloc_idx_1]);
            ok2 = alloc_valid_2 && alloc_fu_2 != 2'd3 && !(alloc_valid_1 && alloc_idx_1 == alloc_idx_2)
                  && (m_st[alloc_idx_2] == 0 || gone[alloc_idx_2]);
            if ((alloc_valid_1 && !ok1) || (alloc_valid_2 && !ok2)) m_err = 1'b1;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_st[i] = 0;
                m_ord.delete();
                m_iv = '0; m_free = '0; m_occ = 0;
            end else begin
                for (int f = 0; f < 3; f++) begin
                    win[f] = -1;
                    foreach (m_ord[k])
                        if (win[f] < 0 && m_st[m_ord[k]] == 1 && m_fu[m_ord[k]] == f && src_ready[m_ord[k]])
                            win[f] = m_ord[k];
                end
                for (int f = 0; f < 3; f++) begin
                    if (!m_iv[f] || fu_ready[f]) begin
                        m_iv[f] = (win[f] >= 0);
                        if (win[f] >= 0) begin m_ix[f] = win[f]; m_st[win[f]] = 2; end
                    end
                end
                for (int k = m_ord.size() - 1; k >= 0; k--)
                    if (gone[m_ord[k]]) begin m_st[m_ord[k]] = 0; m_ord.delete(k); end
                if (ok1) begin m_st[alloc_idx_1] = 1; m_fu[alloc_idx_1] = alloc_fu_1; m_ord.push_back(alloc_idx_1); end
                if (ok2) begin m_st[alloc_idx_2] = 1; m_fu[alloc_idx_2] = alloc_fu_2; m_ord.push_back(alloc_idx_2); end
                m_free = gone;
                m_occ  = m_ord.size();
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst && !tb_done) begin
            cmp("m_issue_valid", issue_valid, m_iv);
            for (int f = 0; f < 3; f++)
                if (m_iv[f]) cmp($sformatf("m_issue_idx%0d", f), issue_idx[f*4 +: 4], m_ix[f]);
            cmp("m_rs_free", rs_free, m_free);
            cmp("m_occupancy", occupancy, m_occ);
            cmp("m_alloc_err", alloc_err, m_err);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic no_alloc();
        alloc_valid_1 = 1'b0;
        alloc_valid_2 = 1'b0;
    endtask

    task automatic alloc1(input int idx, input int fu);
        alloc_valid_1 = 1'b1; alloc_idx_1 = 4'(idx); alloc_fu_1 = 2'(fu);
    endtask

    task automatic alloc2(input int idx, input int fu);
        alloc_valid_2 = 1'b1; alloc_idx_2 = 4'(idx); alloc_fu_2 = 2'(fu);
    endtask

    task automatic do_reset();
        rst = 1'b1; no_alloc(); flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        cmp("rst_valid", issue_valid, 0);
        cmp("rst_idx", issue_idx, 0);
        cmp("rst_free", rs_free, 0);
        cmp("rst_occ", occupancy, 0);
        cmp("rst_err", alloc_err, 0);

        // 1: single alloc, issue two edges later, free one after that
        src_ready = '1; fu_ready = 3'b111;
        alloc1(3, 0); tick(); no_alloc();
        cmp("t1_occ", occupancy, 1);
        cmp("t1_early", issue_valid, 0);
        tick();
        cmp("t1_valid", issue_valid, 3'b001);
        cmp("t1_idx", issue_idx[3:0], 3);
        tick();
        cmp("t1_free", rs_free, 16'h0008);
        cmp("t1_occ0", occupancy, 0);
        tick();
        cmp("t1_free_off", rs_free, 0);

        // 2: age beats index order
        src_ready = '0;
        alloc1(5, 1); tick();
        alloc1(2, 1); tick(); no_alloc();
        tick();
        src_ready = '1; tick();
        cmp("t2_first", issue_idx[7:4], 5);
        tick();
        cmp("t2_second", issue_idx[7:4], 2);
        cmp("t2_free5", rs_free, 16'h0020);
        tick();
        cmp("t2_free2", rs_free, 16'h0004);
        cmp("t2_drain", issue_valid, 0);

        // 3: stalled MEM port holds steady
        fu_ready = 3'b011;
        alloc1(7, 2); tick(); no_alloc(); tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            cmp("t3_hold_v", issue_valid[2], 1);
            cmp("t3_hold_idx", issue_idx[11:8], 7);
            cmp("t3_no_free", rs_free, 0);
        end
        fu_ready = 3'b111; tick();
        cmp("t3_free7", rs_free, 16'h0080);
        cmp("t3_empty", issue_valid, 0);
        tick();
        cmp("t3_once", rs_free, 0);

        // 4: duplicate index pair and illegal FU
        src_ready = '0;
        alloc1(4, 0); alloc2(4, 1); tick(); no_alloc();
        cmp("t4_err_dup", alloc_err, 1);
        cmp("t4_occ", occupancy, 1);
        do_reset();
        alloc1(9, 3); tick(); no_alloc();
        cmp("t4_err_fu3", alloc_err, 1);
        cmp("t4_occ_fu3", occupancy, 0);

        // 5: fill all lines, flush with three pending issues
        do_reset();
        src_ready = '1; fu_ready = 3'b000;
        for (int k = 0; k < 8; k++) begin
            alloc1(2*k, (2*k) % 3); alloc2(2*k+1, (2*k+1) % 3); tick();
        end
        no_alloc(); tick();
        cmp("t5_full", occupancy, 16);
        cmp("t5_pending", issue_valid, 3'b111);
        flush = 1'b1; fu_ready = 3'b111; tick(); flush = 1'b0;
        cmp("t5_flush_v", issue_valid, 0);
        cmp("t5_flush_occ", occupancy, 0);
        cmp("t5_flush_free", rs_free, 0);
        tick();
        cmp("t5_after_free", rs_free, 0);

        // 6: async reset mid-stall, then hand-off and realloc of the same line
        fu_ready = 3'b110;
        alloc1(6, 0); tick(); no_alloc(); tick(); tick();
        cmp("t6_stall", issue_idx[3:0], 6);
        #2 rst = 1'b1;
        #1;
        cmp("t6_rst_v", issue_valid, 0);
        cmp("t6_rst_occ", occupancy, 0);
        cmp("t6_rst_idx", issue_idx, 0);
        tick(); rst = 1'b0;
        alloc1(6, 0); tick(); no_alloc(); tick();
        cmp("t6_iss", issue_valid, 3'b001);
        fu_ready = 3'b111; alloc1(6, 0); tick(); no_alloc();
        cmp("t6_occ_same", occupancy, 1);
        cmp("t6_free6", rs_free, 16'h0040);
        cmp("t6_err", alloc_err, 0);
        tick();
        cmp("t6_reissue", issue_valid, 3'b001);
        cmp("t6_reidx", issue_idx[3:0], 6);
        tick(); tick();

        tb_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
